// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------
// serial_adder_pkg : shared FSM state type and default width
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------
// serial_adder_if : start/operand request and result bundle
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b,
    input  ready, busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, sum, carry_out
  );

endinterface

`default_nettype wire

// File: rtl/full_adder.sv
// ---------------------------------------------------------------
// full_adder : two cascaded half adders with the carries OR-ed
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic carry_in,
  output logic sum,
  output logic carry
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (
    .in1   (in1),
    .in2   (in2),
    .sum   (w_s0),
    .carry (w_c0)
  );

  half_adder u_ha1 (
    .in1   (w_s0),
    .in2   (carry_in),
    .sum   (sum),
    .carry (w_c1)
  );

  assign carry = w_c0 | w_c1;

endmodule

`default_nettype wire

// File: rtl/half_adder.sv
// ---------------------------------------------------------------
// half_adder : one-bit sum and carry of two inputs
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module half_adder (
  input  logic in1,
  input  logic in2,
  output logic sum,
  output logic carry
);

  assign sum   = in1 ^ in2;
  assign carry = in1 & in2;

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------
// serial_adder : bit-serial WIDTH-bit adder, one bit per clock
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic fa_sum;
  logic fa_carry;

  full_adder u_fa (
    .in1      (a_q[0]),
    .in2      (b_q[0]),
    .carry_in (carry_q),
    .sum      (fa_sum),
    .carry    (fa_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Sum fills from the MSB so bit 0 lands in place after WIDTH shifts
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_carry;
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ready     = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------
// tb_serial_adder : random and directed checks against a cycle-count model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: cycles remaining until back in idle; the result is known once done is due
  int               m_left    = 0;
  bit               m_have    = 1'b1;
  logic [WIDTH:0]   m_exp     = '0;
  int               m_accepts = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_have = 1'b1;
      m_exp  = '0;
    end else if (m_left == 0) begin
      if (bus.start === 1'b1) begin
        m_exp  = {1'b0, bus.a} + {1'b0, bus.b};
        m_left = WIDTH + 1;
        m_have = 1'b0;
        m_accepts++;
      end
    end else begin
      m_left--;
      if (m_left == 1) m_have = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("ready", 64'(bus.ready), 64'(m_left == 0));
      check("busy",  64'(bus.busy),  64'(m_left >= 2));
      check("done",  64'(bus.done),  64'(m_left == 1));
      if (m_have) check("result", 64'({bus.carry_out, bus.sum}), 64'(m_exp));
      if (bus.done === 1'b1) n_done++;
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH:0] exp, input string name);
    int t;
    t = 0;
    while (bus.ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({name, " ready"}, 64'(bus.ready), 64'(1));
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    t = 1;
    while (bus.done !== 1'b1 && t < WIDTH + 4) begin
      @(negedge clk);
      t++;
    end
    check({name, " latency"}, 64'(t), 64'(WIDTH + 1));
    check({name, " sum"}, 64'({bus.carry_out, bus.sum}), 64'(exp));
    @(negedge clk);
  endtask

  initial begin
    int target;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst ready", 64'(bus.ready), 64'(1));
    check("rst busy",  64'(bus.busy),  64'(0));
    check("rst done",  64'(bus.done),  64'(0));
    check("rst sum",   64'({bus.carry_out, bus.sum}), 64'(0));
    #2 rst = 1'b0;
    @(negedge clk);

    run_op(8'h00, 8'h00, 9'h000, "zero");
    run_op(8'hFF, 8'h01, 9'h100, "ff+01");
    run_op(8'h5A, 8'h3C, 9'h096, "5a+3c");
    run_op(8'hFF, 8'hFF, 9'h1FE, "ff+ff");
    repeat (5) @(negedge clk);
    check("hold ff+ff", 64'({bus.carry_out, bus.sum}), 64'(9'h1FE));

    // Back-to-back requests with operands changing every cycle
    bus.start = 1'b1;
    repeat (40) begin
      bus.a = WIDTH'($urandom);
      bus.b = WIDTH'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (WIDTH + 3) @(negedge clk);

    // Asynchronous abort four edges into a run
    while (bus.ready !== 1'b1) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hC3;
    bus.b     = 8'h7E;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort ready", 64'(bus.ready), 64'(1));
    check("abort busy",  64'(bus.busy),  64'(0));
    check("abort done",  64'(bus.done),  64'(0));
    check("abort sum",   64'({bus.carry_out, bus.sum}), 64'(0));
    #1 rst = 1'b0;
    @(negedge clk);
    run_op(8'h12, 8'h34, 9'h046, "post-abort");

    target = m_accepts + 1000;
    for (int c = 0; c < 15000 && m_accepts < target; c++) begin
      bus.start = (($urandom % 4) != 0);
      bus.a     = WIDTH'($urandom);
      bus.b     = WIDTH'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("sweep reached", 64'(m_accepts >= target), 64'(1));
    repeat (WIDTH + 3) @(negedge clk);
    check("done count", 64'(n_done), 64'(m_accepts - 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to add a and b; sampled on rising clk edge.
REQ-005 a  input  WIDTH  operand A; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  operand B; sampled only on the edge that accepts start.
REQ-007 ready  output  1  high when idle and able to accept start.
REQ-008 busy  output  1  high while bit-serial addition is in progress.
REQ-009 done  output  1  one-cycle pulse; sum and carry_out valid.
REQ-010 sum  output  WIDTH  result (a + b) mod 2^WIDTH.
REQ-011 carry_out  output  1  carry out of the MSB.

Function
REQ-012 FSM states IDLE, RUN, DONE; ready = (state==IDLE), busy = (state==RUN), done = (state==DONE), all registered-state decodes.
REQ-013 IDLE with start=1 at edge k: capture a and b into operand shift registers, clear carry flop, clear bit counter, go to RUN.
REQ-014 IDLE with start=0: remain in IDLE; sum and carry_out hold.
REQ-015 RUN, each edge: add LSBs of both operand registers plus carry flop with one full-adder instance; shift sum bit into sum register MSB (sum shifts right); store new carry; shift both operand registers right by one; increment counter.
REQ-016 RUN lasts exactly WIDTH edges (k+1..k+WIDTH); on edge k+WIDTH, state goes to DONE with the final bit written.
REQ-017 DONE lasts exactly one cycle; next edge returns to IDLE unconditionally.
REQ-018 Latency: done high in the cycle between edges k+WIDTH and k+WIDTH+1; earliest next accepted start at edge k+WIDTH+2.
REQ-019 start while in RUN or DONE is ignored; no operand capture, no effect on the current operation.
REQ-020 a and b changing after acceptance has no effect on the result.
REQ-021 sum and carry_out reflect the completed operation from the DONE cycle onward and hold until the next accepted start; during RUN they are undefined to the user.
REQ-022 Bit counter width $clog2(WIDTH)+1; no wrap-around within an operation.

Reset
REQ-023 rst=1 forces, without waiting for clk: state IDLE, ready=1, busy=0, done=0, sum=0, carry_out=0, carry flop 0, counter 0, operand registers 0.
REQ-024 rst asserted mid-RUN or in DONE aborts the operation; no done pulse is produced for it.
REQ-025 First start accepted at the first rising edge after rst deasserts.

Structure
REQ-026 Shared package serial_adder_pkg holds the FSM state enum type and the default WIDTH constant.
REQ-027 One sub-module full_adder (in1, in2, carry_in -> sum, carry), built from two half_adder instances plus an OR, instantiated once as the only arithmetic in the block.

Verification (WIDTH=8)
REQ-028 start with a=0x00, b=0x00 at edge k -> busy on edges k+1..k+8, done pulse after k+8, sum=0x00, carry_out=0.
REQ-029 a=0xFF, b=0x01 -> sum=0x00, carry_out=1; a=0x5A, b=0x3C -> sum=0x96, carry_out=0.
REQ-030 a=0xFF, b=0xFF -> sum=0xFE, carry_out=1; values hold through 5 idle cycles afterwards.
REQ-031 start held high continuously with a/b changing each cycle -> operations accepted every WIDTH+2 edges, each result matches the operands present at its accepting edge.
REQ-032 rst pulsed between clock edges during RUN (edge k+4) -> all outputs immediately at reset values, no done pulse; next start yields correct result.
REQ-033 Random sweep of 1000 operand pairs -> every {carry_out,sum} equals a+b, done exactly once per accepted start.
